// File: rtl/core_pkg.sv
// Shared RV32I core definitions: writeback/ALU selectors, opcodes and the
// decoded control bundle carried through the ID/EX register.
package core_pkg;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC  = 2'b10;

  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_BR  = 2'b01;
  localparam logic [1:0] ALU_OP_R   = 2'b10;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] mem_reg_pc;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jl;
    logic       jlr;
    logic       alu_src;
    logic [1:0] alu_op;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_NOP = '{
    reg_write:  1'b0,
    mem_reg_pc: WB_SEL_ALU,
    mem_read:   1'b0,
    mem_write:  1'b0,
    branch:     1'b0,
    jl:         1'b0,
    jlr:        1'b0,
    alu_src:    1'b0,
    alu_op:     ALU_OP_ADD
  };

  // Unused encoding 11 and any unknown value collapse to the ALU select.
  function automatic logic [1:0] wb_sanitize(input logic [1:0] sel);
    case (sel)
      WB_SEL_MEM: wb_sanitize = WB_SEL_MEM;
      WB_SEL_PC:  wb_sanitize = WB_SEL_PC;
      default:    wb_sanitize = WB_SEL_ALU;
    endcase
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: a valid load in EX whose non-zero destination
// matches either source index of the valid instruction in ID.
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  output logic              stall_o
);

  // Deliberately ignores whether the ID instruction actually reads the source.
  assign stall_o = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid &
                   ((ex_rd == id_rs1) | (ex_rd == id_rs2));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush/hold/bubble handling.
// Load-use stall generation is built only when ID_EX_LOAD_USE_EN is defined.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic              id_reg_write,
  input  logic [1:0]        id_mem_reg_pc,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_branch,
  input  logic              id_jl,
  input  logic              id_jlr,
  input  logic              id_alu_src,
  input  logic [1:0]        id_alu_op,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [2:0]        id_f3,
  input  logic [6:0]        id_f7,
  input  logic              flush,
  input  logic              hold,
  output logic              ex_reg_write,
  output logic [1:0]        ex_mem_reg_pc,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch,
  output logic              ex_jl,
  output logic              ex_jlr,
  output logic              ex_alu_src,
  output logic [1:0]        ex_alu_op,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [2:0]        ex_f3,
  output logic [6:0]        ex_f7,
  output logic              ex_valid,
  output logic              stall_o
);

  ctrl_bundle_t      ctrl_q, ctrl_d, id_ctrl;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic [REG_AW-1:0] rs1_q, rs1_d;
  logic [REG_AW-1:0] rs2_q, rs2_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [2:0]        f3_q, f3_d;
  logic [6:0]        f7_q, f7_d;

`ifdef ID_EX_LOAD_USE_EN
  load_use_detect #(
    .REG_AW (REG_AW)
  ) u_load_use_detect (
    .ex_valid    (valid_q),
    .ex_mem_read (ctrl_q.mem_read),
    .ex_rd       (rd_q),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .stall_o     (stall_o)
  );
`else
  assign stall_o = 1'b0;
`endif

  always_comb begin
    id_ctrl = '{
      reg_write:  id_reg_write,
      mem_reg_pc: wb_sanitize(id_mem_reg_pc),
      mem_read:   id_mem_read,
      mem_write:  id_mem_write,
      branch:     id_branch,
      jl:         id_jl,
      jlr:        id_jlr,
      alu_src:    id_alu_src,
      alu_op:     id_alu_op
    };
  end

  // Priority: flush, then hold, then load-use bubble, then normal capture.
  always_comb begin
    ctrl_d     = ctrl_q;
    valid_d    = valid_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    f3_d       = f3_q;
    f7_d       = f7_q;
    if (flush || (!hold && stall_o)) begin
      ctrl_d     = CTRL_NOP;
      valid_d    = 1'b0;
      pc_d       = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
      rs1_d      = '0;
      rs2_d      = '0;
      rd_d       = '0;
      f3_d       = '0;
      f7_d       = '0;
    end else if (!hold) begin
      ctrl_d     = id_valid ? id_ctrl : CTRL_NOP;
      valid_d    = id_valid;
      pc_d       = id_pc;
      rs1_data_d = id_rs1_data;
      rs2_data_d = id_rs2_data;
      imm_d      = id_imm;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      rd_d       = id_rd;
      f3_d       = id_f3;
      f7_d       = id_f7;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= CTRL_NOP;
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      f3_q       <= '0;
      f7_q       <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      f3_q       <= f3_d;
      f7_q       <= f7_d;
    end
  end

  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_reg_pc = ctrl_q.mem_reg_pc;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_branch     = ctrl_q.branch;
  assign ex_jl         = ctrl_q.jl;
  assign ex_jlr        = ctrl_q.jlr;
  assign ex_alu_src    = ctrl_q.alu_src;
  assign ex_alu_op     = ctrl_q.alu_op;
  assign ex_valid      = valid_q;
  assign ex_pc         = pc_q;
  assign ex_rs1_data   = rs1_data_q;
  assign ex_rs2_data   = rs2_data_q;
  assign ex_imm        = imm_q;
  assign ex_rs1        = rs1_q;
  assign ex_rs2        = rs2_q;
  assign ex_rd         = rd_q;
  assign ex_f3         = f3_q;
  assign ex_f7         = f7_q;

endmodule
